cu_alloc_scanner: RTL

// - Front-end sequencer for the per-CU workgroup throttling engine. Accepts one WG allocation

---
 rtl/cu_alloc_scanner_if.sv | 42 ++++
 rtl/cu_alloc_scanner.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cu_alloc_scanner_if.sv
// Request/grant/engine bundle between the WG dispatcher, the allocation scanner
// and the per-CU throttling engine. The scanner sits on the master side.
//
// Handshakes: a transfer on alloc_req or dealloc happens in the cycle where
// valid and ready are both high. The requester holds valid until it sees
// ready. grant_valid_o stays high with a stable grant_cu_id_o until grant_ack_i.
`ifndef WG_SLOT_ID_WIDTH
`define WG_SLOT_ID_WIDTH 6
`endif

interface cu_alloc_scanner_if #(
  parameter int CU_ID_WIDTH = 1,
  parameter int AVAIL_WIDTH = `WG_SLOT_ID_WIDTH + 1
);
  logic                   alloc_req_valid_i;
  logic                   alloc_req_ready_o;
  logic                   dealloc_valid_i;
  logic [CU_ID_WIDTH-1:0] dealloc_cu_id_i;
  logic                   dealloc_ready_o;
  logic                   grant_valid_o;
  logic [CU_ID_WIDTH-1:0] grant_cu_id_o;
  logic                   grant_ack_i;
  logic                   alloc_fail_o;
  logic [CU_ID_WIDTH-1:0] te_cu_id_o;
  logic                   te_alloc_en_o;
  logic                   te_dealloc_en_o;
  logic [AVAIL_WIDTH-1:0] te_wg_count_available_i;

  modport master (
    input  alloc_req_valid_i, dealloc_valid_i, dealloc_cu_id_i, grant_ack_i,
           te_wg_count_available_i,
    output alloc_req_ready_o, dealloc_ready_o, grant_valid_o, grant_cu_id_o,
           alloc_fail_o, te_cu_id_o, te_alloc_en_o, te_dealloc_en_o
  );

  modport slave (
    output alloc_req_valid_i, dealloc_valid_i, dealloc_cu_id_i, grant_ack_i,
           te_wg_count_available_i,
    input  alloc_req_ready_o, dealloc_ready_o, grant_valid_o, grant_cu_id_o,
           alloc_fail_o, te_cu_id_o, te_alloc_en_o, te_dealloc_en_o
  );
endinterface

// File: rtl/cu_alloc_scanner.sv
// Round-robin CU allocation scanner in front of the WG throttling engine.
// One request in flight; deallocs take priority in IDLE. te_cu_id_o is held
// through each engine pulse and the following SETTLE cycle, because the engine
// applies the update one cycle after the pulse using that cycle's cu_id.
`ifndef WG_SLOT_ID_WIDTH
`define WG_SLOT_ID_WIDTH 6
`endif

module cu_alloc_scanner #(
  parameter int NUMBER_CU   = 2,
  parameter int CU_ID_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cu_alloc_scanner_if.master    bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEALLOC = 3'd1,
    S_PROBE   = 3'd2,
    S_CHECK   = 3'd3,
    S_GRANT   = 3'd4,
    S_COMMIT  = 3'd5,
    S_SETTLE  = 3'd6
  } state_t;

  localparam logic [CU_ID_WIDTH-1:0] LAST_CU = CU_ID_WIDTH'(NUMBER_CU - 1);

  state_t                 state;
  state_t                 state_next;
  logic [CU_ID_WIDTH-1:0] rr_ptr;
  logic [CU_ID_WIDTH-1:0] probe_cnt;
  logic [CU_ID_WIDTH-1:0] te_cu_id;
  logic [CU_ID_WIDTH-1:0] grant_cu_id;
  logic                   alloc_fail;
  logic                   avail_nz;
  logic                   last_probe;

  // Wrap is explicit so non-power-of-2 CU counts never step past the last CU.
  function automatic logic [CU_ID_WIDTH-1:0] next_cu(input logic [CU_ID_WIDTH-1:0] cu);
    next_cu = (cu == LAST_CU) ? '0 : cu + 1'b1;
  endfunction

  assign avail_nz   = |bus.te_wg_count_available_i;
  assign last_probe = (probe_cnt == LAST_CU);
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.dealloc_valid_i)        state_next = S_DEALLOC;
        else if (bus.alloc_req_valid_i) state_next = S_PROBE;
      end
      S_DEALLOC: state_next = S_SETTLE;
      S_PROBE:   state_next = S_CHECK;
      S_CHECK: begin
        if (avail_nz)        state_next = S_GRANT;
        else if (last_probe) state_next = S_IDLE;
        else                 state_next = S_PROBE;
      end
      S_GRANT:  if (bus.grant_ack_i) state_next = S_COMMIT;
      S_COMMIT: state_next = S_SETTLE;
      S_SETTLE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Registered datapath: probe cursor, grant id, rr pointer, fail pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      probe_cnt   <= '0;
      te_cu_id    <= '0;
      grant_cu_id <= '0;
      alloc_fail  <= 1'b0;
    end else begin
      alloc_fail <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.dealloc_valid_i) begin
            te_cu_id <= bus.dealloc_cu_id_i;
          end else if (bus.alloc_req_valid_i) begin
            te_cu_id  <= rr_ptr;
            probe_cnt <= '0;
          end
        end
        S_CHECK: begin
          if (avail_nz) begin
            grant_cu_id <= te_cu_id;
          end else if (last_probe) begin
            alloc_fail <= 1'b1;
          end else begin
            te_cu_id  <= next_cu(te_cu_id);
            probe_cnt <= probe_cnt + 1'b1;
          end
        end
        S_COMMIT: rr_ptr <= next_cu(grant_cu_id);
        default: ;
      endcase
    end
  end

  // Outputs: readies only in IDLE (forced low while reset is held), pulses by state.
  always_comb begin
    bus.alloc_req_ready_o = 1'b0;
    bus.dealloc_ready_o   = 1'b0;
    if (state == S_IDLE && !rst) begin
      bus.dealloc_ready_o   = bus.dealloc_valid_i;
      bus.alloc_req_ready_o = !bus.dealloc_valid_i;
    end
    bus.grant_valid_o   = (state == S_GRANT);
    bus.grant_cu_id_o   = grant_cu_id;
    bus.alloc_fail_o    = alloc_fail;
    bus.te_cu_id_o      = te_cu_id;
    bus.te_alloc_en_o   = (state == S_COMMIT);
    bus.te_dealloc_en_o = (state == S_DEALLOC);
  end

endmodule
